// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundles the IF/ID instruction feed and the pipeline control outputs of the
// hazard controller into one port.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             id_valid;
    logic [15:0]      id_instr;
    logic             pc_en;
    logic             pc_clr;
    logic             stall;
    logic             bubble;
    logic             issue;
    logic             busy;
    logic             halted;
    logic [15:0]      sb_pending;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output start, id_valid, id_instr,
        input  pc_en, pc_clr, stall, bubble, issue, busy, halted, sb_pending, stall_cnt
    );

    modport slave (
        input  start, id_valid, id_instr,
        output pc_en, pc_clr, stall, bubble, issue, busy, halted, sb_pending, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Issue/hazard controller for the 4-stage IF/ID/EX/WB 8-bit core: per-register
// write scoreboard, stall/bubble generation and run/halt/drain sequencing.
module pipeline_hazard_ctrl #(
    parameter int WB_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STALL,
        S_DRAIN,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_LOAD = 4'h3;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [2:0] LAT     = 3'(WB_LAT);

    state_t           state_q, state_d;
    logic [2:0]       cnt_q [16];
    logic [2:0]       cnt_d [16];
    logic [1:0]       drain_q, drain_d;
    logic             pc_clr_q, pc_clr_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [15:0] pending;
    logic [3:0]  opcode, dest, src1, src2;
    logic        reads_regs, writes_reg, hazard;
    logic        pc_en, stall, bubble, issue;

    always_comb begin
        for (int r = 0; r < 16; r++) begin
            pending[r] = (cnt_q[r] != 3'd0);
        end
    end

    assign opcode     = bus.id_instr[15:12];
    assign dest       = bus.id_instr[11:8];
    assign src1       = bus.id_instr[7:4];
    assign src2       = bus.id_instr[3:0];
    assign reads_regs = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign writes_reg = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_LOAD);
    // Uses the counters as they stand, so a self-dependent instruction sees only older writes.
    assign hazard     = bus.id_valid && reads_regs && (pending[src1] || pending[src2]);

    always_comb begin
        pc_en       = 1'b0;
        stall       = 1'b0;
        bubble      = 1'b0;
        issue       = 1'b0;
        state_d     = state_q;
        drain_d     = drain_q;
        pc_clr_d    = 1'b0;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    state_d     = S_RUN;
                    pc_clr_d    = 1'b1;
                    stall_cnt_d = '0;
                end
            end
            S_RUN, S_STALL: begin
                if (hazard) begin
                    stall   = 1'b1;
                    bubble  = 1'b1;
                    state_d = S_STALL;
                end else if (bus.id_valid && (opcode == OP_HALT)) begin
                    issue   = 1'b1;
                    state_d = S_DRAIN;
                    drain_d = 2'd1;
                end else begin
                    pc_en   = 1'b1;
                    issue   = bus.id_valid;
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                bubble = 1'b1;
                if (drain_q != 2'd2) begin
                    drain_d = drain_q + 2'd1;
                end
                // drain_q counts edges since HALT issued; two means EX and WB are empty.
                if ((drain_q == 2'd2) && (pending == 16'h0000)) begin
                    state_d = S_HALT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!reset) begin
            pc_en  = 1'b0;
            stall  = 1'b0;
            bubble = 1'b0;
            issue  = 1'b0;
        end

        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        for (int r = 0; r < 16; r++) begin
            cnt_d[r] = (cnt_q[r] != 3'd0) ? cnt_q[r] - 3'd1 : 3'd0;
            if (issue && writes_reg && (dest == 4'(r))) begin
                cnt_d[r] = LAT;
            end
        end

        busy_d   = (state_d == S_RUN) || (state_d == S_STALL) || (state_d == S_DRAIN);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            drain_q     <= 2'd0;
            pc_clr_q    <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            for (int r = 0; r < 16; r++) begin
                cnt_q[r] <= 3'd0;
            end
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            pc_clr_q    <= pc_clr_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
            for (int r = 0; r < 16; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign bus.pc_en      = pc_en;
    assign bus.stall      = stall;
    assign bus.bubble     = bubble;
    assign bus.issue      = issue;
    assign bus.pc_clr     = pc_clr_q;
    assign bus.busy       = busy_q;
    assign bus.halted     = halted_q;
    assign bus.sb_pending = pending;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios then random
// traffic, every cycle checked against a cycle-counting reference model.
module tb_pipeline_hazard_ctrl;

    localparam int WB_LAT  = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int MD_IDLE  = 0;
    localparam int MD_RUN   = 1;
    localparam int MD_DRAIN = 2;
    localparam int MD_HALT  = 3;

    typedef struct packed {
        logic [6:0]  ctrl;
        logic [15:0] pend;
        logic [15:0] scnt;
    } exp_t;

    logic clk;
    logic reset;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(.WB_LAT(WB_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: pipeline mode, cycles left per pending write, cycle stamps.
    int   mode = MD_IDLE;
    int   pend[16];
    int   cyc = 0;
    int   halt_cyc = 0;
    int   m_scnt = 0;
    bit   m_pc_clr = 0, m_busy = 0, m_halted = 0;
    bit   last_issue = 0, last_pc_en = 0;

    initial begin
        for (int r = 0; r < 16; r++) pend[r] = 0;
    end

    function automatic logic [15:0] mk(input int op, input int d, input int s1, input int s2);
        mk = {4'(op), 4'(d), 4'(s1), 4'(s2)};
    endfunction

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("[TB] FAIL %s at t=%0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    task automatic apply_stimulus(input bit rst_n, input bit st, input bit v, input logic [15:0] ins);
        int   op, d, s1, s2;
        bit   e_pc_en, e_stall, e_bubble, e_issue, haz, all_zero;
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rst_n;
        bus.start    = st;
        bus.id_valid = v;
        bus.id_instr = ins;

        op = int'(ins[15:12]); d = int'(ins[11:8]); s1 = int'(ins[7:4]); s2 = int'(ins[3:0]);
        haz = v && (op == 1 || op == 2) && (pend[s1] > 0 || pend[s2] > 0);
        e_pc_en = 0; e_stall = 0; e_bubble = 0; e_issue = 0;
        if (rst_n && mode == MD_RUN) begin
            if (haz) begin
                e_stall = 1; e_bubble = 1;
            end else if (v && op == 15) begin
                e_issue = 1;
            end else begin
                e_pc_en = 1; e_issue = v;
            end
        end else if (rst_n && mode == MD_DRAIN) begin
            e_bubble = 1;
        end
        e.ctrl = {e_pc_en, m_pc_clr, e_stall, e_bubble, e_issue, m_busy, m_halted};
        for (int r = 0; r < 16; r++) e.pend[r] = (pend[r] > 0);
        e.scnt = 16'(m_scnt);
        exp_q.push_back(e);

        if (!rst_n) begin
            mode = MD_IDLE; m_scnt = 0; m_pc_clr = 0;
            for (int r = 0; r < 16; r++) pend[r] = 0;
        end else begin
            all_zero = 1;
            for (int r = 0; r < 16; r++) if (pend[r] > 0) all_zero = 0;
            for (int r = 0; r < 16; r++) if (pend[r] > 0) pend[r]--;
            if (e_issue && (op == 1 || op == 2 || op == 3)) pend[d] = WB_LAT;
            if (e_stall && m_scnt < CNT_MAX) m_scnt++;
            m_pc_clr = 0;
            case (mode)
                MD_IDLE, MD_HALT: if (st) begin mode = MD_RUN; m_pc_clr = 1; m_scnt = 0; end
                MD_RUN:   if (e_issue && op == 15) begin mode = MD_DRAIN; halt_cyc = cyc; end
                MD_DRAIN: if (cyc - halt_cyc >= 2 && all_zero) mode = MD_HALT;
                default:  mode = MD_IDLE;
            endcase
        end
        m_busy   = (mode == MD_RUN) || (mode == MD_DRAIN);
        m_halted = (mode == MD_HALT);
        last_issue = e_issue;
        last_pc_en = e_pc_en;
        cyc++;
    endtask

    // Holds one instruction in IF/ID until the model says it issues.
    task automatic feed(input logic [15:0] ins);
        int n = 0;
        do begin
            apply_stimulus(1, 0, 1, ins);
            n++;
        end while (!last_issue && n < 20);
        n_checks++;
        if (!last_issue) begin
            n_errors++;
            $display("[TB] FAIL feed_timeout: instr %h not issued, expected issue within 20 cycles", ins);
        end
    endtask

    task automatic wait_halted();
        int n = 0;
        while (bus.halted !== 1'b1 && n < 20) begin
            apply_stimulus(1, 0, 0, 16'h0000);
            n++;
        end
        n_checks++;
        if (bus.halted !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL halt_wait: halted=%b, expected 1 within 20 cycles", bus.halted);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_output("ctrl{pc_en,pc_clr,stall,bubble,issue,busy,halted}",
                         {9'd0, bus.pc_en, bus.pc_clr, bus.stall, bus.bubble, bus.issue, bus.busy, bus.halted},
                         {9'd0, e.ctrl});
            check_output("sb_pending", bus.sb_pending, e.pend);
            check_output("stall_cnt", {12'd0, bus.stall_cnt}, e.scnt);
        end
    end

    function automatic logic [15:0] rand_instr();
        int k, op;
        k = $urandom_range(0, 19);
        if (k < 6)       op = 1;
        else if (k < 10) op = 2;
        else if (k < 13) op = 3;
        else if (k < 15) op = 0;
        else if (k < 16) op = 15;
        else             op = $urandom_range(4, 14);
        rand_instr = mk(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    endfunction

    initial begin
        logic [15:0] cur_ins;
        bit          cur_v, st, rn;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.id_valid = 1'b0;
        bus.id_instr = 16'h0000;

        repeat (3) apply_stimulus(0, 0, 0, 16'h0000);
        apply_stimulus(1, 0, 0, 16'h0000);
        apply_stimulus(1, 1, 0, 16'h0000);
        apply_stimulus(1, 0, 0, 16'h0000);

        feed(mk(1, 1, 2, 3));
        feed(mk(2, 4, 1, 2));
        feed(mk(3, 5, 0, 8));
        feed(mk(1, 6, 2, 3));
        feed(mk(1, 1, 2, 3));
        feed(mk(1, 1, 3, 2));
        feed(mk(2, 7, 1, 1));
        feed(mk(1, 1, 1, 2));
        feed(mk(1, 1, 2, 3));
        feed(mk(15, 0, 0, 0));
        apply_stimulus(1, 1, 0, 16'h0000);
        wait_halted();
        apply_stimulus(1, 0, 0, 16'h0000);
        apply_stimulus(1, 1, 0, 16'h0000);
        feed(mk(1, 1, 2, 3));
        apply_stimulus(1, 0, 1, mk(2, 4, 1, 2));
        apply_stimulus(0, 0, 1, mk(2, 4, 1, 2));
        apply_stimulus(1, 0, 1, mk(2, 4, 1, 2));
        apply_stimulus(1, 0, 0, 16'h0000);

        cur_ins = 16'h0000;
        cur_v   = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (last_pc_en || last_issue || !cur_v) begin
                cur_ins = rand_instr();
                cur_v   = ($urandom_range(0, 4) != 0);
            end
            if (mode == MD_IDLE || mode == MD_HALT) st = ($urandom_range(0, 5) == 0);
            else                                      st = ($urandom_range(0, 15) == 0);
            rn = ($urandom_range(0, 199) != 0);
            apply_stimulus(rn, st, cur_v, cur_ins);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Issue/hazard controller for the 4-stage IF/ID/EX/WB 8-bit processor.
- Keeps a per-register scoreboard of in-flight writes and evaluates the instruction sitting in IF/ID each cycle.
- Drives the stall, bubble and fetch-enable controls, and sequences run/halt/drain of the whole pipeline.
- Instruction format: [15:12] opcode, [11:8] dest, [7:4] src1, [3:0] src2/imm. Opcodes: NOP=0, ADD=1, SUB=2, LOAD=3, HALT=F.

Parameters:
- WB_LAT, 2, cycles from issue until the result is readable from reg_file. Legal range 1..7.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins execution from IDLE or HALT.
- id_valid  in  1  IF/ID holds a valid instruction.
- id_instr  in  16  IF/ID instruction.
- pc_en  out  1  advance PC and load IF/ID.
- pc_clr  out  1  one-cycle pulse; clear PC and pipeline registers.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  load NOP into ID/EX this cycle.
- issue  out  1  IF/ID instruction moves to EX this cycle.
- busy  out  1  state is not IDLE and not HALT.
- halted  out  1  state is HALT.
- sb_pending  out  16  bit r = register r has a write in flight.
- stall_cnt  out  CNT_W  saturating count of stall cycles since the last start.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE, all scoreboard counters=0, stall_cnt=0.
  - Registered outputs reset to 0; combinational outputs evaluate to 0 in IDLE.
- Scoreboard:
  - One 3-bit down-counter per register.
  - sb_pending[r] = (cnt[r] != 0).
  - Each cycle every nonzero counter decrements by 1.
  - On issue of an ADD, SUB or LOAD, cnt[dest] is loaded with WB_LAT in the next cycle. The load overrides the decrement, so WAW simply reloads the counter.
- Source usage:
  - ADD/SUB read src1 and src2.
  - LOAD, NOP, HALT and undefined opcodes (4..E) read no registers.
  - Undefined opcodes are treated as NOP: no dest write, no scoreboard update.
- hazard (combinational) = id_valid and the opcode reads a register whose counter is nonzero (src1, or src2).
- States:
  - IDLE: pc_en=0. On start, pulse pc_clr and go to RUN.
  - RUN:
    - If hazard: stall=1, bubble=1, pc_en=0, issue=0, go to STALL.
    - Else if id_valid and opcode=HALT: issue=1, pc_en=0, go to DRAIN.
    - Else: pc_en=1, and issue=id_valid.
  - STALL: same outputs as a RUN hazard while hazard persists. When hazard clears, issue in that same cycle with RUN semantics (including the HALT check) and return to RUN.
  - DRAIN:
    - pc_en=0, bubble=1, issue=0.
    - When all counters are 0 and 2 cycles have elapsed since the HALT issue (EX/WB empty), go to HALT.
  - HALT:
    - halted=1; outputs as IDLE.
    - On start, pulse pc_clr, clear stall_cnt and go to RUN.
- Outputs:
  - stall, bubble, issue and pc_en are combinational from state, counters and id_instr. They are valid in the same cycle.
  - pc_clr, halted, busy and stall_cnt are registered.
- stall_cnt:
  - Increments in every cycle with stall=1.
  - Saturates at all-ones; does not wrap.
- Back-to-back dependency: a dependent instruction stalls exactly WB_LAT cycles after its producer issues.
- start received while busy is ignored.
- id_valid=0 in RUN: pc_en=1, issue=0, no scoreboard update.
- Reset asserted in any state (mid-stall, mid-drain): return to IDLE, clear counters, and issue nothing on that edge.
- Self-dependency (e.g. ADD R1,R1,R2): the hazard check uses the counters before this instruction's own dest update.

Test Plan:
- Reset held 3 cycles, then released → state IDLE, sb_pending=0, stall_cnt=0, all controls 0. Pulse start → pc_clr high exactly 1 cycle, then pc_en=1.
- WB_LAT=2: ADD R1,R2,R3 then SUB R4,R1,R2 → stall=1 for exactly 2 cycles, SUB issues on the 3rd, stall_cnt=2, sb_pending[1] high for 2 cycles.
- LOAD R5,MEM[8] then ADD R6,R2,R3 → no stall (independent), issue every cycle, sb_pending=0x0020 then 0x0060.
- ADD R1,… ; ADD R1,… ; SUB R7,R1,R1 → counter reloaded by the second ADD, SUB stalls 2 cycles after the second ADD issues, single hazard window.
- HALT after ADD R1 → pc_en drops the cycle HALT issues, halted=1 after counters clear plus 2 cycles. start mid-drain is ignored; start in HALT restarts with stall_cnt=0.
- Drive reset=0 during STALL with sb_pending=0x0002 → next cycle IDLE, sb_pending=0, no issue pulse.
